// File: rtl/tcore_param.sv
// Shared core parameters and bus types for the data-side memory path.
// Holds the dcache <-> bridge request/response structs, the word-bus
// request/response pair, and the bridge FSM / transaction-class encodings.
// No ports; imported by dmem_bridge and its bench.
package tcore_param;

  localparam int XLEN     = 32;
  localparam int BLK_SIZE = 128;

  // dcache miss / write-back request towards the lower level
  typedef struct packed {
    logic                valid;
    logic                ready;
    logic                uncached;
    logic [XLEN-1:0]     addr;
    logic                rw;
    logic [1:0]          rw_size;
    logic [BLK_SIZE-1:0] data;
  } dlowX_req_t;

  // lower-level response back to the dcache
  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } dlowX_res_t;

  // word-bus pair; the bridge ports stay flat until the core moves to these
  typedef struct packed {
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [31:0]     wdata;
    logic [3:0]      be;
  } dmem_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } dmem_res_t;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_REQ  = 2'd1,
    DM_WAIT = 2'd2,
    DM_DONE = 2'd3
  } dmem_state_e;

  typedef enum logic [1:0] {
    TXN_LINE_RD = 2'd0,
    TXN_LINE_WR = 2'd1,
    TXN_UNC_RD  = 2'd2,
    TXN_UNC_WR  = 2'd3
  } dmem_txn_e;

  // A full-size write is always a line write-back, even if flagged uncached.
  // Any other write is a single-word partial write.
  function automatic dmem_txn_e dmem_classify(input logic       uncached,
                                              input logic       rw,
                                              input logic [1:0] rw_size);
    dmem_txn_e cls;
    if (rw && (rw_size == 2'b11)) cls = TXN_LINE_WR;
    else if (!rw)                 cls = uncached ? TXN_UNC_RD : TXN_LINE_RD;
    else                          cls = TXN_UNC_WR;
    return cls;
  endfunction

endpackage

// File: rtl/dmem_bridge.sv
// dmem_bridge: converts dcache line/uncached requests into a sequence of
// single-word requests on a req/gnt/rvalid memory bus, one outstanding at a
// time, and assembles read words back into a cache line.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   lowX_req_i    dcache request {valid, ready, uncached, addr, rw, rw_size, data}
//   lowX_res_o    response to dcache {valid, ready, data}
//   mem_req_o     word request
//   mem_we_o      1 = write
//   mem_addr_o    word-aligned address
//   mem_wdata_o   write data
//   mem_be_o      byte enables
//   mem_gnt_i     request accepted
//   mem_rvalid_i  read data valid / write ack, one per granted request
//   mem_rdata_i   read data
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a dcache request, captures it on valid
// REQ     | word request presented, held stable until gnt
// WAIT    | granted, waiting for rvalid of the current beat
// DONE    | one-cycle response to the dcache
module dmem_bridge
  import tcore_param::*;
#(
  parameter int BLK_SIZE = tcore_param::BLK_SIZE,
  parameter int XLEN     = tcore_param::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  dlowX_req_t      lowX_req_i,
  output dlowX_res_t      lowX_res_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [31:0]     mem_wdata_o,
  output logic [3:0]      mem_be_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [31:0]     mem_rdata_i
);

  localparam int NBEATS  = BLK_SIZE / 32;
  localparam int BOFFSET = $clog2(BLK_SIZE / 8);
  localparam int BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  dmem_state_e         state_q, state_d;
  dmem_txn_e           txn_q;
  logic [XLEN-1:0]     addr_q;
  logic [1:0]          size_q;
  logic [BLK_SIZE-1:0] data_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [BLK_SIZE-1:0] line_q;

  logic              is_line;
  logic              is_write;
  logic              last_beat;
  logic [BEAT_W-1:0] lane;
  logic [XLEN-1:0]   beat_addr;
  logic [31:0]       beat_wdata;
  logic [3:0]        beat_be;

  // the dcache's own ready has no meaning on this side
  logic unused_req_ready;
  assign unused_req_ready = lowX_req_i.ready;

  assign is_line   = (txn_q == TXN_LINE_RD) || (txn_q == TXN_LINE_WR);
  assign is_write  = (txn_q == TXN_LINE_WR) || (txn_q == TXN_UNC_WR);
  assign last_beat = !is_line || (beat_q == LAST_BEAT);
  assign lane      = addr_q[BOFFSET-1:2];

  always_comb begin
    beat_addr  = '0;
    beat_wdata = '0;
    beat_be    = 4'hF;
    if (is_line) begin
      beat_addr  = {addr_q[XLEN-1:BOFFSET], beat_q, 2'b00};
      beat_wdata = data_q[{beat_q, 5'b0} +: 32];
    end else begin
      beat_addr  = {addr_q[XLEN-1:2], 2'b00};
      beat_wdata = data_q[{lane, 5'b0} +: 32];
    end
    if (txn_q == TXN_UNC_WR) begin
      case (size_q)
        2'b01:   beat_be = 4'b0011 << {addr_q[1], 1'b0};
        2'b10:   beat_be = 4'b0001 << addr_q[1:0];
        default: beat_be = 4'hF;
      endcase
    end
  end

  // Outputs depend only on registered state so ready never loops back
  // through the dcache's valid.
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    lowX_res_o  = '0;
    case (state_q)
      DM_IDLE: begin
        lowX_res_o.ready = 1'b1;
        if (lowX_req_i.valid) state_d = DM_REQ;
      end
      DM_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = is_write;
        mem_addr_o  = beat_addr;
        mem_wdata_o = is_write ? beat_wdata : 32'h0;
        mem_be_o    = beat_be;
        if (mem_gnt_i) state_d = DM_WAIT;
      end
      DM_WAIT: begin
        if (mem_rvalid_i) state_d = last_beat ? DM_DONE : DM_REQ;
      end
      DM_DONE: begin
        lowX_res_o.valid = 1'b1;
        lowX_res_o.data  = is_write ? '0 : line_q;
        state_d          = DM_IDLE;
      end
      default: state_d = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DM_IDLE;
      txn_q   <= TXN_LINE_RD;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        DM_IDLE: begin
          if (lowX_req_i.valid) begin
            txn_q  <= dmem_classify(lowX_req_i.uncached, lowX_req_i.rw,
                                    lowX_req_i.rw_size);
            addr_q <= lowX_req_i.addr;
            size_q <= lowX_req_i.rw_size;
            data_q <= lowX_req_i.data;
            beat_q <= '0;
            // cleared here so an uncached read returns zeros in other lanes
            line_q <= '0;
          end
        end
        DM_WAIT: begin
          if (mem_rvalid_i) begin
            if (txn_q == TXN_LINE_RD) line_q[{beat_q, 5'b0} +: 32] <= mem_rdata_i;
            if (txn_q == TXN_UNC_RD)  line_q[{lane, 5'b0} +: 32]   <= mem_rdata_i;
            if (!last_beat) beat_q <= beat_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;
  import tcore_param::*;

  logic        clk = 1'b0;
  logic        rst;
  dlowX_req_t  lowX_req;
  dlowX_res_t  lowX_res;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  dmem_bridge #(.BLK_SIZE(128), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .lowX_req_i(lowX_req), .lowX_res_o(lowX_res),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  typedef struct {
    logic         unc;
    logic         rw;
    logic [1:0]   size;
    logic [31:0]  addr;
    logic [127:0] data;
    int           dly_beat;
    int           dly;
    logic [127:0] exp_data;
    int           exp_lat;
  } vec_t;

  beat_t        mem_q[$];
  logic [127:0] res_q[$];
  vec_t         vecs[10];

  int n_checks = 0;
  int n_fail   = 0;

  // driver-owned
  bit   mem_auto = 1'b1;
  bit   busy = 1'b0;
  int   txn_id = 0;
  int   gnt_dly_beat = -1;
  int   gnt_dly = 0;
  logic m_gnt, m_rv;
  logic [31:0] m_rdata;

  // monitor/responder-owned
  int   resp_cnt = 0;
  int   ready_bad = 0;
  int   stab_bad = 0;
  logic a_gnt = 1'b0, a_rv = 1'b0;
  logic [31:0] a_rdata = '0;

  assign mem_gnt    = mem_auto ? a_gnt   : m_gnt;
  assign mem_rvalid = mem_auto ? a_rv    : m_rv;
  assign mem_rdata  = mem_auto ? a_rdata : m_rdata;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: which word accesses a request must produce.
  function automatic void push_exp(input vec_t v);
    beat_t b;
    int    ln;
    if (v.rw && v.size == 2'b11) begin
      for (int k = 0; k < 4; k++) begin
        b.we = 1'b1; b.addr = (v.addr & 32'hFFFF_FFF0) + 32'(4 * k);
        b.wdata = v.data[32*k +: 32]; b.be = 4'hF;
        mem_q.push_back(b);
      end
    end else if (!v.rw && !v.unc) begin
      for (int k = 0; k < 4; k++) begin
        b.we = 1'b0; b.addr = (v.addr & 32'hFFFF_FFF0) + 32'(4 * k);
        b.wdata = '0; b.be = 4'hF;
        mem_q.push_back(b);
      end
    end else begin
      ln = int'(v.addr[3:2]);
      b.we = v.rw; b.addr = v.addr & 32'hFFFF_FFFC;
      b.wdata = v.data[32*ln +: 32];
      case (v.size)
        2'b01:   b.be = v.addr[1] ? 4'b1100 : 4'b0011;
        2'b10:   case (v.addr[1:0])
                   2'd0: b.be = 4'b0001;
                   2'd1: b.be = 4'b0010;
                   2'd2: b.be = 4'b0100;
                   default: b.be = 4'b1000;
                 endcase
        default: b.be = 4'hF;
      endcase
      mem_q.push_back(b);
    end
  endfunction

  // Response monitor and memory responder (addr-as-data, gnt after an
  // optional stall, rvalid one cycle after gnt).
  bit          rv_pend = 1'b0;
  logic [31:0] rv_data = '0;
  bit          holding = 1'b0;
  beat_t       hold;
  int          wait_left = 0;
  int          seen_id = -1;
  int          beat_idx = 0;

  always @(negedge clk) begin
    bit    outstanding;
    beat_t e;
    if (busy && lowX_res.ready) ready_bad++;
    if (lowX_res.valid) begin
      resp_cnt++;
      if (res_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_res: got valid with data %h expected no response", lowX_res.data);
      end else begin
        check("res_data", lowX_res.data, res_q.pop_front());
      end
    end
    if (!mem_auto) begin
      a_gnt = 1'b0; a_rv = 1'b0; rv_pend = 1'b0; holding = 1'b0;
    end else begin
      outstanding = rv_pend;
      a_rv = rv_pend; a_rdata = rv_data; rv_pend = 1'b0;
      a_gnt = 1'b0;
      if (txn_id != seen_id) begin seen_id = txn_id; beat_idx = 0; end
      if (mem_req) begin
        if (outstanding) stab_bad++;
        if (!holding) begin
          holding = 1'b1;
          hold.we = mem_we; hold.addr = mem_addr; hold.wdata = mem_wdata; hold.be = mem_be;
          wait_left = (beat_idx == gnt_dly_beat) ? gnt_dly : 0;
        end else if (hold.we !== mem_we || hold.addr !== mem_addr ||
                     hold.wdata !== mem_wdata || hold.be !== mem_be) begin
          stab_bad++;
        end
        if (wait_left == 0) begin
          a_gnt = 1'b1; holding = 1'b0;
          rv_pend = 1'b1; rv_data = mem_addr;
          beat_idx++;
          if (mem_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_mem: got req addr %h we %b expected none", mem_addr, mem_we);
          end else begin
            e = mem_q.pop_front();
            check("mem_addr", mem_addr, e.addr);
            check("mem_we", mem_we, e.we);
            if (e.we) begin
              check("mem_wdata", mem_wdata, e.wdata);
              check("mem_be", mem_be, e.be);
            end
          end
        end else begin
          wait_left--;
        end
      end else if (holding) begin
        stab_bad++;
        holding = 1'b0;
      end
    end
  end

  task automatic drive_req(input vec_t v);
    lowX_req.valid    = 1'b1;
    lowX_req.ready    = 1'b1;
    lowX_req.uncached = v.unc;
    lowX_req.addr     = v.addr;
    lowX_req.rw       = v.rw;
    lowX_req.rw_size  = v.size;
    lowX_req.data     = v.data;
  endtask

  task automatic scramble_req();
    lowX_req.valid    = 1'b0;
    lowX_req.uncached = 1'($urandom);
    lowX_req.addr     = $urandom;
    lowX_req.rw       = 1'($urandom);
    lowX_req.rw_size  = 2'($urandom);
    lowX_req.data     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_txn(input vec_t v);
    int r0, s0, c_set;
    bit done;
    @(negedge clk);
    check("ready_idle", lowX_res.ready, 1);
    push_exp(v);
    res_q.push_back(v.exp_data);
    gnt_dly_beat = v.dly_beat; gnt_dly = v.dly; txn_id++;
    r0 = ready_bad; s0 = stab_bad;
    drive_req(v);
    c_set = cyc;
    @(negedge clk);
    scramble_req();
    busy = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (lowX_res.valid) begin done = 1'b1; break; end
      @(negedge clk);
    end
    busy = 1'b0;
    check("done", done, 1);
    check("latency", cyc - c_set, v.exp_lat);
    check("ready_low", ready_bad - r0, 0);
    check("mem_stable", stab_bad - s0, 0);
    check("beats_left", mem_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0;
    bit  done;
    //        unc  rw    size    addr           data                                        dbeat dly exp_data                                   lat
    vecs[0] = '{1'b0, 1'b0, 2'b11, 32'h0000_1234, 128'h0,                                      -1, 0, 128'h0000123C_00001238_00001234_00001230,  9};
    vecs[1] = '{1'b0, 1'b1, 2'b11, 32'h0000_2000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,    -1, 0, 128'h0,                                    9};
    vecs[2] = '{1'b1, 1'b1, 2'b10, 32'h1000_0003, 128'h44444444_33333333_22222222_00000055,    -1, 0, 128'h0,                                    3};
    vecs[3] = '{1'b1, 1'b0, 2'b00, 32'h1000_0008, 128'h0,                                      -1, 0, 128'h00000000_10000008_00000000_00000000,  3};
    vecs[4] = '{1'b0, 1'b0, 2'b11, 32'h0000_0040, 128'h0,                                       2, 5, 128'h0000004C_00000048_00000044_00000040, 14};
    vecs[5] = '{1'b1, 1'b1, 2'b01, 32'h0000_2006, 128'h00000000_00000000_12345678_00000000,    -1, 0, 128'h0,                                    3};
    vecs[6] = '{1'b1, 1'b1, 2'b00, 32'h0000_300C, 128'hCAFEF00D_11111111_22222222_33333333,    -1, 0, 128'h0,                                    3};
    vecs[7] = '{1'b1, 1'b0, 2'b01, 32'h0000_0104, 128'h0,                                       0, 2, 128'h00000000_00000000_00000104_00000000,  5};
    vecs[8] = '{1'b0, 1'b1, 2'b11, 32'h0000_5008, 128'h44444444_33333333_22222222_11111111,     3, 1, 128'h0,                                   10};
    vecs[9] = '{1'b1, 1'b1, 2'b10, 32'h0000_7001, 128'h00000000_00000000_00000000_0000AB00,    -1, 0, 128'h0,                                    3};

    rst = 1'b1;
    lowX_req = '0;
    m_gnt = 1'b0; m_rv = 1'b0; m_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",   mem_req, 0);
    check("rst_we",    mem_we, 0);
    check("rst_addr",  mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_be",    mem_be, 0);
    check("rst_valid", lowX_res.valid, 0);
    check("rst_ready", lowX_res.ready, 1);
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // reset in WAIT of beat 1, then a stray rvalid
    @(negedge clk);
    mem_auto = 1'b0;
    r0 = resp_cnt;
    drive_req(vecs[0]);
    lowX_req.addr = 32'h0000_0800;
    @(negedge clk);
    lowX_req.valid = 1'b0;
    check("mr_req0", mem_req, 1);
    check("mr_addr0", mem_addr, 32'h0000_0800);
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0; m_rv = 1'b1; m_rdata = 32'h1111_1111;
    @(negedge clk);
    m_rv = 1'b0;
    check("mr_addr1", mem_addr, 32'h0000_0804);
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_rv = 1'b1; m_rdata = 32'hBAD0_BAD0;
    check("mr_rst_ready", lowX_res.ready, 1);
    check("mr_rst_req", mem_req, 0);
    check("mr_rst_addr", mem_addr, 0);
    @(negedge clk);
    m_rv = 1'b0;
    check("mr_stray_ready", lowX_res.ready, 1);
    check("mr_stray_req", mem_req, 0);
    repeat (3) @(negedge clk);
    check("mr_no_res", resp_cnt - r0, 0);
    mem_auto = 1'b1;
    run_txn(vecs[0]);

    // request held valid across DONE is taken again from the following IDLE
    @(negedge clk);
    push_exp(vecs[3]); push_exp(vecs[3]);
    res_q.push_back(vecs[3].exp_data); res_q.push_back(vecs[3].exp_data);
    gnt_dly_beat = -1; gnt_dly = 0; txn_id++;
    r0 = resp_cnt;
    drive_req(vecs[3]);
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lowX_res.valid) begin done = 1'b1; break; end
    end
    check("b2b_first", done, 1);
    @(negedge clk);
    check("b2b_ready", lowX_res.ready, 1);
    @(negedge clk);
    lowX_req.valid = 1'b0;
    check("b2b_req", mem_req, 1);
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lowX_res.valid) begin done = 1'b1; break; end
    end
    check("b2b_second", done, 1);
    repeat (2) @(negedge clk);
    check("b2b_count", resp_cnt - r0, 2);

    repeat (3) @(negedge clk);
    check("mem_q_empty", mem_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
